lock_controller: RTL and testbench
==================================

// Module: lock_controller
// PURPOSE
//  Code-entry lock FSM. It consumes divided_clk from clk_divider as a slow sample strobe.
//  It samples the keypad buttons once per slow tick, compares a CODE_LEN-digit sequence
//  against CODE, and drives unlocked/lockout status to the VGA status display.
//  Runs entirely in the clk_in domain; divided_clk is treated as data, never as a clock.
// PARAMETERS
//  CODE_LEN       4          digits per attempt (2..7)
//  CODE           8'h1B      expected digits, digit0 in CODE[1:0]; 2 bits per digit
//  MAX_FAILS      3          consecutive bad attempts before LOCKOUT (1..3)
//  ENTRY_TIMEOUT  40         ticks without a press in ENTRY before abandoning the attempt
//  UNLOCK_TICKS   200        ticks in UNLOCKED before automatic relock
//  LOCKOUT_TICKS  100        ticks spent in LOCKOUT
// PORTS
//  clk_in      in   1  system clock
//  rst         in   1  synchronous, active-high reset
//  slow_clk    in   1  divided_clk from clk_divider (asynchronous-safe level)
//  btn         in   4  raw keypad buttons, one-hot when valid; digit = bit index
//  lock_btn    in   1  raw manual relock button
//  unlocked    out  1  high in UNLOCKED
//  lockout     out  1  high in LOCKOUT
//  digit_cnt   out  3  digits entered in the current attempt
//  fail_cnt    out  2  consecutive failed attempts
//  ok_pulse    out  1  1-cycle pulse on a correct attempt
//  err_pulse   out  1  1-cycle pulse on an incorrect attempt
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timer, mismatch flag and sampled buttons are cleared.
//  Sync: slow_clk, btn and lock_btn each pass through 2 flops.
//  Tick: 1-cycle pulse when sync(slow_clk)=1 and the previous sync value=0.
//    Tick latency is 3 clk_in cycles after the slow_clk rise.
//  Sampling: btn and lock_btn are sampled only on tick. This debounces them.
//  Press event: the previous sample is 0 and the new sample has exactly one bit set.
//    A multi-bit sample is ignored and is not counted as a digit.
//    A held button produces one press only.
//  lock_ev: the lock_btn sample goes 0->1.
//  Timer: one shared tick counter, width $clog2 of the largest *_TICKS parameter.
//    Clears on every state change and on every press; increments on tick.
//  FSM (all outputs are registered and update the cycle after the tick that causes the event):
//    IDLE:     press -> ENTRY, digit_cnt=1, mismatch=(digit!=CODE[1:0]).
//    ENTRY:    press -> digit_cnt++, mismatch |= (digit!=CODE[2i+1:2i]).
//              On the CODE_LEN-th press:
//                mismatch=0 -> UNLOCKED, ok_pulse, fail_cnt=0.
//                otherwise  -> err_pulse and fail_cnt++; if the new value is MAX_FAILS,
//                              go to LOCKOUT, else go to IDLE.
//              Timer reaching ENTRY_TIMEOUT -> IDLE; fail_cnt is unchanged.
//              digit_cnt returns to 0 on every exit from ENTRY.
//    UNLOCKED: lock_ev, or timer reaching UNLOCK_TICKS -> IDLE. Presses are ignored.
//    LOCKOUT:  timer reaching LOCKOUT_TICKS -> IDLE, fail_cnt=0.
//              Presses and lock_ev are ignored.
//  Simultaneous events on one tick:
//    press and timeout -> press wins.
//    lock_ev and timeout in UNLOCKED -> IDLE (single transition).
//  fail_cnt saturates at MAX_FAILS and never wraps.
//  rst asserted mid-attempt returns to the reset state on the next edge. No pulse is emitted.
// STRUCTURE
//  lock_defs.vh: state encoding localparams (IDLE=0, ENTRY=1, UNLOCKED=2, LOCKOUT=3)
//    and the digit width (2). Shared with the VGA status renderer.
//  Sub-module slow_tick_gen: 2-flop sync plus rising-edge detect producing tick.
//  The button synchronisers reuse the same 2-flop cell, without the edge detect.
// TESTING  (bench: CODE=8'h1B, CODE_LEN=4, MAX_FAILS=3, timeouts 4/6/5; slow_clk period 20 clk_in)
//  Reset, then tick with no buttons -> unlocked=0, lockout=0, digit_cnt=0, fail_cnt=0.
//  Press digits 3,2,1,0, one per tick with release between
//    -> ok_pulse once; unlocked=1 the cycle after the 4th press; fail_cnt=0.
//  Enter 3,2,1,1 three times -> err_pulse x3, fail_cnt 1,2,3; lockout=1.
//    After 5 ticks: lockout=0, fail_cnt=0. Presses during lockout leave digit_cnt=0.
//  Hold btn=4'b0001 for 10 ticks -> digit_cnt=1 only.
//    btn=4'b0011 -> digit_cnt unchanged.
//  Enter 2 digits, then idle 4 ticks -> digit_cnt=0, state=IDLE, fail_cnt unchanged.
//  Unlocked then lock_btn pulse -> unlocked=0.
//    Unlocked then idle 6 ticks -> unlocked=0.
//    Assert rst mid-entry -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/lock_controller_pkg.sv
// Shared definitions for the code-entry lock: state encoding, digit width and
// keypad decode helpers.
package lock_controller_pkg;

  localparam int unsigned DigitW = 2;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StEntry    = 2'd1,
    StUnlocked = 2'd2,
    StLockout  = 2'd3
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [DigitW-1:0] onehot_to_digit(input logic [3:0] v);
    logic [DigitW-1:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) d = DigitW'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Keypad-side inputs and status outputs of the lock controller.
interface lock_controller_if;
  logic       slow_clk;
  logic [3:0] btn;
  logic       lock_btn;
  logic       unlocked;
  logic       lockout;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;
  logic       ok_pulse;
  logic       err_pulse;

  modport master (
    output slow_clk, btn, lock_btn,
    input  unlocked, lockout, digit_cnt, fail_cnt, ok_pulse, err_pulse
  );

  modport slave (
    input  slow_clk, btn, lock_btn,
    output unlocked, lockout, digit_cnt, fail_cnt, ok_pulse, err_pulse
  );
endinterface

// File: rtl/lock_controller_slow_tick_gen.sv
// Turns the divided clock level into a one-cycle tick, three clk_in cycles
// after its rising edge.
module lock_controller_slow_tick_gen (
  input  logic clk_in,
  input  logic rst,
  input  logic i_slow_clk,
  output logic o_tick
);

  logic w_sync;
  logic r_prev;
  logic r_tick;

  lock_controller_sync2 #(
    .WIDTH (1)
  ) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .i_d    (i_slow_clk),
    .o_q    (w_sync)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_prev <= w_sync;
      r_tick <= w_sync & ~r_prev;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/lock_controller_sync2.sv
// Two-flop synchroniser cell for asynchronous level inputs.
module lock_controller_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lock_controller.sv
// Code-entry lock FSM: samples the keypad once per slow tick, checks a digit
// sequence against CODE and reports unlock/lockout status.
module lock_controller
  import lock_controller_pkg::*;
#(
  parameter int unsigned CODE_LEN      = 4,
  parameter logic [13:0] CODE          = 14'h001B,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned ENTRY_TIMEOUT = 40,
  parameter int unsigned UNLOCK_TICKS  = 200,
  parameter int unsigned LOCKOUT_TICKS = 100
) (
  input  logic             clk_in,
  input  logic             rst,
  lock_controller_if.slave io_bus
);

  localparam int unsigned MaxA     = (ENTRY_TIMEOUT > UNLOCK_TICKS) ? ENTRY_TIMEOUT : UNLOCK_TICKS;
  localparam int unsigned MaxTicks = (MaxA > LOCKOUT_TICKS) ? MaxA : LOCKOUT_TICKS;
  localparam int unsigned TimerW   = $clog2(MaxTicks + 1);

  logic              w_tick;
  logic [4:0]        w_in_sync;
  logic [3:0]        w_btn_sync;
  logic              w_lock_sync;
  logic              w_press;
  logic              w_lock_ev;
  logic [DigitW-1:0] w_digit;
  logic [DigitW-1:0] w_code_digit;
  logic              w_mismatch_new;
  logic              w_last;
  logic [1:0]        w_fail_inc;
  logic              w_entry_to;
  logic              w_unlock_to;
  logic              w_lockout_to;

  state_e            r_state, w_state_d;
  logic [TimerW-1:0] r_timer, w_timer_d;
  logic [3:0]        r_btn_smp;
  logic              r_lock_smp;
  logic [2:0]        r_digit_cnt, w_digit_cnt_d;
  logic [1:0]        r_fail_cnt, w_fail_cnt_d;
  logic              r_mismatch, w_mismatch_d;
  logic              r_ok, w_ok_d;
  logic              r_err, w_err_d;
  logic              r_unlocked, r_lockout;

  lock_controller_slow_tick_gen u_tick (
    .clk_in     (clk_in),
    .rst        (rst),
    .i_slow_clk (io_bus.slow_clk),
    .o_tick     (w_tick)
  );

  lock_controller_sync2 #(
    .WIDTH (5)
  ) u_btn_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .i_d    ({io_bus.lock_btn, io_bus.btn}),
    .o_q    (w_in_sync)
  );

  assign w_btn_sync  = w_in_sync[3:0];
  assign w_lock_sync = w_in_sync[4];

  // Press needs an all-released previous sample, so a held key counts once.
  assign w_press        = w_tick & (r_btn_smp == 4'd0) & is_onehot4(w_btn_sync);
  assign w_lock_ev      = w_tick & ~r_lock_smp & w_lock_sync;
  assign w_digit        = onehot_to_digit(w_btn_sync);
  assign w_code_digit   = DigitW'(CODE >> (DigitW * r_digit_cnt));
  assign w_mismatch_new = r_mismatch | (w_digit != w_code_digit);
  assign w_last         = (r_digit_cnt == 3'(CODE_LEN - 1));
  assign w_fail_inc     = (r_fail_cnt == 2'(MAX_FAILS)) ? r_fail_cnt : r_fail_cnt + 2'd1;
  assign w_entry_to     = w_tick & (r_timer == TimerW'(ENTRY_TIMEOUT - 1));
  assign w_unlock_to    = w_tick & (r_timer == TimerW'(UNLOCK_TICKS - 1));
  assign w_lockout_to   = w_tick & (r_timer == TimerW'(LOCKOUT_TICKS - 1));

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_press) w_state_d = StEntry;
      end
      StEntry: begin
        if (w_press) begin
          if (w_last) begin
            if (!w_mismatch_new)              w_state_d = StUnlocked;
            else if (w_fail_inc == 2'(MAX_FAILS)) w_state_d = StLockout;
            else                              w_state_d = StIdle;
          end
        end else if (w_entry_to) begin
          w_state_d = StIdle;
        end
      end
      StUnlocked: begin
        if (w_lock_ev || w_unlock_to) w_state_d = StIdle;
      end
      StLockout: begin
        if (w_lockout_to) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_timer_d     = r_timer;
    w_digit_cnt_d = r_digit_cnt;
    w_fail_cnt_d  = r_fail_cnt;
    w_mismatch_d  = r_mismatch;
    w_ok_d        = 1'b0;
    w_err_d       = 1'b0;

    // Presses only restart the timer where they are accepted.
    if ((w_state_d != r_state) || (w_press && (r_state inside {StIdle, StEntry}))) begin
      w_timer_d = '0;
    end else if (w_tick) begin
      w_timer_d = r_timer + 1'b1;
    end

    if (w_press && (r_state inside {StIdle, StEntry})) begin
      w_digit_cnt_d = r_digit_cnt + 3'd1;
      w_mismatch_d  = w_mismatch_new;
      if (r_state == StEntry && w_last) begin
        if (!w_mismatch_new) begin
          w_ok_d       = 1'b1;
          w_fail_cnt_d = 2'd0;
        end else begin
          w_err_d      = 1'b1;
          w_fail_cnt_d = w_fail_inc;
        end
      end
    end

    if (r_state == StEntry && w_state_d != StEntry) begin
      w_digit_cnt_d = 3'd0;
      w_mismatch_d  = 1'b0;
    end

    if (r_state == StLockout && w_state_d == StIdle) w_fail_cnt_d = 2'd0;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_timer     <= '0;
      r_btn_smp   <= 4'd0;
      r_lock_smp  <= 1'b0;
      r_digit_cnt <= 3'd0;
      r_fail_cnt  <= 2'd0;
      r_mismatch  <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_unlocked  <= 1'b0;
      r_lockout   <= 1'b0;
    end else begin
      if (w_tick) begin
        r_btn_smp  <= w_btn_sync;
        r_lock_smp <= w_lock_sync;
      end
      r_timer     <= w_timer_d;
      r_digit_cnt <= w_digit_cnt_d;
      r_fail_cnt  <= w_fail_cnt_d;
      r_mismatch  <= w_mismatch_d;
      r_ok        <= w_ok_d;
      r_err       <= w_err_d;
      r_unlocked  <= (w_state_d == StUnlocked);
      r_lockout   <= (w_state_d == StLockout);
    end
  end

  assign io_bus.unlocked  = r_unlocked;
  assign io_bus.lockout   = r_lockout;
  assign io_bus.digit_cnt = r_digit_cnt;
  assign io_bus.fail_cnt  = r_fail_cnt;
  assign io_bus.ok_pulse  = r_ok;
  assign io_bus.err_pulse = r_err;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios then random keypad traffic,
// checked once per slow tick against a tick-level model of the lock rules.
module tb_lock_controller;

  localparam int unsigned CodeLen  = 4;
  localparam logic [13:0] Code     = 14'h001B;
  localparam int unsigned MaxFails = 3;
  localparam int unsigned EntryTo  = 4;
  localparam int unsigned UnlockT  = 6;
  localparam int unsigned LockoutT = 5;

  logic clk = 1'b0;
  logic rst;

  lock_controller_if bus ();

  lock_controller #(
    .CODE_LEN      (CodeLen),
    .CODE          (Code),
    .MAX_FAILS     (MaxFails),
    .ENTRY_TIMEOUT (EntryTo),
    .UNLOCK_TICKS  (UnlockT),
    .LOCKOUT_TICKS (LockoutT)
  ) dut (
    .clk_in (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ok_seen = 0;
  int err_seen = 0;

  // Model: 0 idle, 1 entry, 2 unlocked, 3 lockout.
  int         m_state, m_dcnt, m_fcnt, m_timer, m_ok, m_err;
  bit         m_mism, m_prev_lock;
  logic [3:0] m_prev_btn;

  always @(negedge clk) begin
    if (bus.ok_pulse === 1'b1) ok_seen++;
    if (bus.err_pulse === 1'b1) err_seen++;
  end

  function automatic int code_digit(input int i);
    logic [13:0] c;
    c = Code >> (2 * i);
    return int'(c[1:0]);
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_unlocked"}, 8'(bus.unlocked), 8'(m_state == 2));
    chk({tag, "_lockout"}, 8'(bus.lockout), 8'(m_state == 3));
    chk({tag, "_digit_cnt"}, 8'(bus.digit_cnt), 8'(m_dcnt));
    chk({tag, "_fail_cnt"}, 8'(bus.fail_cnt), 8'(m_fcnt));
    chk({tag, "_ok_count"}, 8'(ok_seen), 8'(m_ok));
    chk({tag, "_err_count"}, 8'(err_seen), 8'(m_err));
  endtask

  task automatic model_reset();
    m_state = 0; m_dcnt = 0; m_fcnt = 0; m_timer = 0;
    m_mism = 0; m_prev_btn = 4'd0; m_prev_lock = 0;
  endtask

  task automatic model_step(input logic [3:0] b, input logic l);
    bit press, lockev;
    int digit, prev_state;
    press  = (m_prev_btn == 4'd0) && ($countones(b) == 1);
    lockev = !m_prev_lock && l;
    digit  = 0;
    for (int i = 0; i < 4; i++) if (b[i]) digit = i;
    m_prev_btn  = b;
    m_prev_lock = l;
    prev_state  = m_state;
    case (m_state)
      0: if (press) begin
        m_state = 1; m_dcnt = 1; m_mism = (digit != code_digit(0));
      end
      1: if (press) begin
        m_mism = m_mism || (digit != code_digit(m_dcnt));
        m_dcnt++;
        if (m_dcnt == CodeLen) begin
          m_dcnt = 0;
          if (!m_mism) begin
            m_state = 2; m_ok++; m_fcnt = 0;
          end else begin
            m_err++;
            if (m_fcnt < MaxFails) m_fcnt++;
            m_state = (m_fcnt == MaxFails) ? 3 : 0;
          end
          m_mism = 0;
        end
      end else begin
        m_timer++;
        if (m_timer >= EntryTo) begin
          m_state = 0; m_dcnt = 0; m_mism = 0;
        end
      end
      2: begin
        m_timer++;
        if (lockev || m_timer >= UnlockT) m_state = 0;
      end
      default: begin
        m_timer++;
        if (m_timer >= LockoutT) begin
          m_state = 0; m_fcnt = 0;
        end
      end
    endcase
    if (m_state != prev_state || (press && prev_state <= 1)) m_timer = 0;
  endtask

  // One slow_clk period of 20 clk cycles with the given button levels.
  task automatic do_tick(input string tag, input logic [3:0] b, input logic l);
    bus.btn = b;
    bus.lock_btn = l;
    repeat (3) @(negedge clk);
    bus.slow_clk = 1'b1;
    repeat (10) @(negedge clk);
    bus.slow_clk = 1'b0;
    model_step(b, l);
    check_all(tag);
    repeat (7) @(negedge clk);
  endtask

  task automatic press_seq(input string tag, input int d0, input int d1, input int d2,
                           input int d3);
    do_tick(tag, 4'(1 << d0), 1'b0); do_tick(tag, 4'd0, 1'b0);
    do_tick(tag, 4'(1 << d1), 1'b0); do_tick(tag, 4'd0, 1'b0);
    do_tick(tag, 4'(1 << d2), 1'b0); do_tick(tag, 4'd0, 1'b0);
    do_tick(tag, 4'(1 << d3), 1'b0); do_tick(tag, 4'd0, 1'b0);
  endtask

  initial begin
    logic [3:0] b;
    logic       l;
    int         r, d;
    rst = 1'b1;
    bus.slow_clk = 1'b0;
    bus.btn = 4'd0;
    bus.lock_btn = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    do_tick("idle_tick", 4'd0, 1'b0);

    press_seq("good_code", 3, 2, 1, 0);
    do_tick("manual_relock", 4'd0, 1'b1);
    do_tick("relock_release", 4'd0, 1'b0);

    for (int k = 0; k < 3; k++) press_seq("bad_code", 3, 2, 1, 1);
    do_tick("lockout_press", 4'b0100, 1'b0);
    do_tick("lockout_rel", 4'd0, 1'b0);
    do_tick("lockout_lock", 4'd0, 1'b1);
    for (int k = 0; k < 4; k++) do_tick("lockout_wait", 4'd0, 1'b0);

    for (int k = 0; k < 10; k++) do_tick("hold_btn", 4'b0001, 1'b0);
    do_tick("multi_btn", 4'b0011, 1'b0);
    do_tick("release", 4'd0, 1'b0);

    do_tick("partial", 4'b1000, 1'b0); do_tick("partial", 4'd0, 1'b0);
    do_tick("partial", 4'b0100, 1'b0);
    for (int k = 0; k < 5; k++) do_tick("entry_timeout", 4'd0, 1'b0);

    press_seq("good_code2", 3, 2, 1, 0);
    for (int k = 0; k < 6; k++) do_tick("unlock_timeout", 4'd0, 1'b0);

    do_tick("pre_rst", 4'b1000, 1'b0); do_tick("pre_rst", 4'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check_all("mid_rst");
    chk("mid_rst_ok_pulse", 8'(bus.ok_pulse), 8'd0);
    chk("mid_rst_err_pulse", 8'(bus.err_pulse), 8'd0);
    rst = 1'b0;
    do_tick("post_rst", 4'd0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      l = 1'b0;
      if (r < 4) begin
        b = 4'd0;
      end else if (r < 8) begin
        d = ($urandom_range(0, 1) == 1) ? code_digit(m_dcnt % CodeLen) : $urandom_range(0, 3);
        b = 4'(1 << d);
      end else if (r == 8) begin
        b = 4'($urandom);
      end else begin
        b = 4'd0;
        l = 1'b1;
      end
      do_tick("random", b, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
